// File: rtl/kpad_pkg.sv
// rtl/kpad_pkg.sv - shared types and constants for the 4x4 keypad scanner
package kpad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Rows are active low and pulled up, so no key down reads as all ones.
  localparam logic [3:0] ROW_IDLE = 4'hF;

  // Hex code per key, indexed by {column, row}; column 0 is leftmost, row 0 is top.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,   // column 3, rows 3..0
    4'hE, 4'h9, 4'h6, 4'h3,   // column 2
    4'hF, 4'h8, 4'h5, 4'h2,   // column 1
    4'h0, 4'h7, 4'h4, 4'h1    // column 0
  };

  // Index of the lowest-numbered low row; the top row wins when several keys share a column.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable width and reset value
module sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two back-to-back flops to resolve metastability on the asynchronous input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/kpad_scan.sv
// rtl/kpad_scan.sv - 4x4 keypad column scanner with debounce; entry register under KPAD_ENTRY_EN
module kpad_scan #(
  parameter int N  = 16,
  parameter int DB = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        pressed,
  output logic [15:0] value
);

  import kpad_pkg::*;

  localparam logic [N-1:0]  DWELL_MAX = '1;
  localparam logic [DB-1:0] DB_MAX    = '1;

  logic [3:0]    w_row_s;

  state_t        r_state,     w_state_nxt;
  logic [1:0]    r_c,         w_c_nxt;
  logic [N-1:0]  r_dwell,     w_dwell_nxt;
  logic [DB-1:0] r_db,        w_db_nxt;
  logic [3:0]    r_pat,       w_pat_nxt;
  logic [1:0]    r_r,         w_r_nxt;
  logic [3:0]    r_key,       w_key_nxt;
  logic          r_key_valid, w_key_valid_nxt;
  logic          r_pressed,   w_pressed_nxt;

  sync2 #(
    .W       (4),
    .RST_VAL (ROW_IDLE)
  ) u_row_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (row),
    .o_q   (w_row_s)
  );

  // State and datapath registers; reset drops any key in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_c         <= 2'd0;
      r_dwell     <= '0;
      r_db        <= '0;
      r_pat       <= ROW_IDLE;
      r_r         <= 2'd0;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_pressed   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_c         <= w_c_nxt;
      r_dwell     <= w_dwell_nxt;
      r_db        <= w_db_nxt;
      r_pat       <= w_pat_nxt;
      r_r         <= w_r_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_pressed   <= w_pressed_nxt;
    end
  end

  // Next-state logic: scan columns, debounce a press, wait for a clean release.
  always_comb begin
    w_state_nxt     = r_state;
    w_c_nxt         = r_c;
    w_dwell_nxt     = r_dwell;
    w_db_nxt        = r_db;
    w_pat_nxt       = r_pat;
    w_r_nxt         = r_r;
    w_key_nxt       = r_key;
    w_key_valid_nxt = 1'b0;
    w_pressed_nxt   = r_pressed;

    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_MAX) begin
          w_dwell_nxt = '0;
          w_db_nxt    = '0;
          if (w_row_s != ROW_IDLE) begin
            w_pat_nxt   = w_row_s;
            w_r_nxt     = lowest_low(w_row_s);
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_c_nxt = r_c + 2'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (w_row_s == r_pat) begin
          // Counter holds matches so far; this clock is match r_db+1.
          if (r_db == DB_MAX) begin
            w_key_nxt       = KEY_MAP[{r_c, r_r}];
            w_key_valid_nxt = 1'b1;
            w_pressed_nxt   = 1'b1;
            w_db_nxt        = '0;
            w_state_nxt     = ST_HELD;
          end else begin
            w_db_nxt = r_db + 1'b1;
          end
        end else begin
          w_state_nxt = ST_SCAN;
          w_c_nxt     = r_c + 2'd1;
          w_dwell_nxt = '0;
          w_db_nxt    = '0;
        end
      end

      ST_HELD: begin
        if (w_row_s == ROW_IDLE) begin
          w_db_nxt    = '0;
          w_state_nxt = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (w_row_s == ROW_IDLE) begin
          if (r_db == DB_MAX) begin
            w_pressed_nxt = 1'b0;
            w_state_nxt   = ST_SCAN;
            w_c_nxt       = r_c + 2'd1;
            w_dwell_nxt   = '0;
            w_db_nxt      = '0;
          end else begin
            w_db_nxt = r_db + 1'b1;
          end
        end else begin
          w_db_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  assign col       = ~(4'b0001 << r_c);
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign pressed   = r_pressed;

`ifdef KPAD_ENTRY_EN
  logic [15:0] r_value;

  // Entry register: shift in each accepted key, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= 16'h0000;
    end else if (clr) begin
      r_value <= 16'h0000;
    end else if (r_key_valid) begin
      r_value <= {r_value[11:0], r_key};
    end
  end

  assign value = r_value;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr;
  assign value        = 16'h0000;
`endif

endmodule

// File: tb/tb_kpad_scan.sv
// tb/tb_kpad_scan.sv - directed table-driven bench for kpad_scan (N=2, DB=3)
module tb_kpad_scan;

`ifdef KPAD_ENTRY_EN
  localparam bit ENTRY = 1'b1;
`else
  localparam bit ENTRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        pressed;
  logic [15:0] value;

  logic [15:0] keys_down;
  int          n_cmp  = 0;
  int          n_fail = 0;

  typedef struct {
    string       name;
    logic [15:0] keys;
    logic [3:0]  code;
    bit          do_clr;
    logic [15:0] exp_value;
  } vec_t;

  vec_t vecs[5];

  kpad_scan #(.N(2), .DB(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .clr       (clr),
    .key       (key),
    .key_valid (key_valid),
    .pressed   (pressed),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys_down[c*4+r]) row[r] = 1'b0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press_and_release(input string name, input logic [15:0] keys,
                                   input logic [3:0] code, input bit do_clr,
                                   input logic [15:0] exp_v, output int lat);
    int pulses = 0;
    int t = 0;
    int rel = 0;
    keys_down = keys;
    while (pulses == 0 && t < 400) begin
      @(negedge clk);
      t++;
      if (key_valid) begin
        pulses++;
        check({name, "_key"}, key, code);
        check({name, "_pressed_on_valid"}, pressed, 1);
        if (do_clr) clr = 1'b1;
      end
    end
    lat = t;
    check({name, "_valid_seen"}, pulses, 1);
    repeat (20) begin
      @(negedge clk);
      clr = 1'b0;
      if (key_valid) pulses++;
    end
    check({name, "_one_pulse"}, pulses, 1);
    check({name, "_still_pressed"}, pressed, 1);
    check({name, "_value"}, value, ENTRY ? exp_v : 16'h0000);
    keys_down = 16'h0000;
    while (pressed && rel < 100) begin
      @(negedge clk);
      rel++;
    end
    check({name, "_release_lat"}, rel, 11);
    check({name, "_value_after"}, value, ENTRY ? exp_v : 16'h0000);
  endtask

  initial begin
    int lat;
    int t;
    int pulses;
    logic [3:0] ec;

    vecs[0] = '{"k1", 16'h0001, 4'h1, 1'b0, 16'h0001};
    vecs[1] = '{"k2", 16'h0010, 4'h2, 1'b0, 16'h0012};
    vecs[2] = '{"kA", 16'h1000, 4'hA, 1'b0, 16'h012A};
    vecs[3] = '{"kD", 16'h8000, 4'hD, 1'b0, 16'h12AD};
    vecs[4] = '{"k5", 16'h0020, 4'h5, 1'b0, 16'h2AD5};

    rst       = 1'b1;
    clr       = 1'b0;
    keys_down = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_pressed", pressed, 0);
    check("rst_value", value, 16'h0000);

    // Idle scan: column advances every 4 clocks.
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("idle_col_%0d", k), col, ec);
      check($sformatf("idle_valid_%0d", k), key_valid, 0);
    end

    // Steady hold of key 6 at column 2, row 1.
    press_and_release("hold6", 16'h0200, 4'h6, 1'b0, 16'h0006, lat);

    // Bounce on key F (column 1, row 3) while its column is being sampled.
    t = 0;
    while (col != 4'b1110 && t < 50) begin @(negedge clk); t++; end
    while (col != 4'b1101 && t < 100) begin @(negedge clk); t++; end
    check("bounce_align", col, 4'b1101);
    keys_down = 16'h0080;
    repeat (3) @(negedge clk);
    keys_down = 16'h0000;
    @(negedge clk);
    press_and_release("bounceF", 16'h0080, 4'hF, 1'b0, 16'h006F, lat);
    check("bounce_lat_ge10", lat >= 10, 1);

    // Clear coinciding with key_valid: key is reported, value is cleared.
    press_and_release("clr4", 16'h0002, 4'h4, 1'b1, 16'h0000, lat);

    // Entry sequence.
    foreach (vecs[i])
      press_and_release(vecs[i].name, vecs[i].keys, vecs[i].code, vecs[i].do_clr,
                        vecs[i].exp_value, lat);
    check("final_value", value, ENTRY ? 16'h2AD5 : 16'h0000);

    // Two keys in column 0: top row wins; then reset while held.
    keys_down = 16'h0005;
    pulses = 0;
    t = 0;
    while (pulses == 0 && t < 400) begin
      @(negedge clk);
      t++;
      if (key_valid) pulses++;
    end
    check("multi_seen", pulses, 1);
    check("multi_key", key, 4'h1);
    repeat (5) @(negedge clk);
    check("multi_held", pressed, 1);
    rst = 1'b1;
    #1;
    check("arst_col", col, 4'b1110);
    check("arst_key", key, 4'h0);
    check("arst_valid", key_valid, 0);
    check("arst_pressed", pressed, 0);
    check("arst_value", value, 16'h0000);
    keys_down = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check("post_rst_no_valid", pulses, 0);
    check("post_rst_pressed", pressed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
